univ_shiftreg: RTL and testbench
================================

# univ_shiftreg

Parametrised universal shift register, the general successor to the lab's fixed 6-bit serial-in/serial-out shifter. It provides hold, shift-right, shift-left and parallel-load modes, optional rotation, and serial outputs at both ends. A saturating fill counter tracks how many valid bits are held, and the register contents are compared against a programmable pattern. This makes the block usable as a serialiser, a deserialiser, or a WIDTH-bit sequence detector in later lab designs.

## Interface
- WIDTH, 6: register width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load
- rot  in  1  when 1, shift modes rotate instead of taking sin
- sin  in  1  serial data input
- pin  in  WIDTH  parallel load data
- pattern  in  WIDTH  compare pattern for match
- q  out  WIDTH  register contents
- so_r  out  1  q[0], the bit leaving on a right shift
- so_l  out  1  q[WIDTH-1], the bit leaving on a left shift
- full  out  1  fill count equals WIDTH
- match  out  1  full and (q == pattern)

## Operation
- Reset: q=0, fill count=0. This gives full=0, match=0, so_r=0, so_l=0. rst overrides every other input.
- Hold (00): q and the fill count are unchanged.
- Shift right (01):
  - rot=0: q <= {sin, q[WIDTH-1:1]}
  - rot=1: q <= {q[0], q[WIDTH-1:1]}
- Shift left (10):
  - rot=0: q <= {q[WIDTH-2:0], sin}
  - rot=1: q <= {q[WIDTH-2:0], q[WIDTH-1]}
- Parallel load (11): q <= pin and fill count <= WIDTH. rot is ignored.
- Fill count:
  - Width is $clog2(WIDTH+1).
  - Increments by 1 on each non-rotating shift and saturates at WIDTH.
  - Unchanged on rotate and on hold.
  - Never wraps.
- Direction change mid-fill: the count keeps incrementing. The count measures shifts taken, not bit positions.
- full = (count == WIDTH).
- match = full & (q == pattern). It is combinational from registered state and the pattern input. It is never 1 while full=0, even if q equals the pattern (for example, q=0 with pattern=0 after reset).
- so_r and so_l are direct taps of the register. They are not separately registered.

## Timing
- Every state change takes effect at the rising clk edge. q, full, so_r and so_l are valid immediately after that edge.
- Latency:
  - Parallel load: data appears on q 1 cycle after the edge where mode=11 is sampled, and full=1 in that same cycle.
  - Serial fill: full rises after the WIDTH-th consecutive non-rotating shift edge.
- Bit order:
  - Shift right: the first bit shifted in lands in q[0] after WIDTH shifts.
  - Shift left: the first bit shifted in lands in q[WIDTH-1] after WIDTH shifts.
- Reset mid-operation: one rst cycle clears q and the count regardless of mode. Shifting restarts from empty on the next non-reset edge.
- Pattern changes affect match within the same cycle. No clock is needed.
- mode, rot, sin and pin must be stable around the rising edge. They are sampled only at the edge.

## Structure
- Shared package univ_shiftreg_pkg holds:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
  - the count-width function
- Sub-module fill_counter handles the saturating, synchronous-reset counter.
  - Ports: clk, rst, inc, load, count, full.
  - Parameter: MAX=WIDTH.
- The top level contains the data register, the next-state mux and the comparator.

## Test plan
- **Reset:** reset with WIDTH=6, pattern=6'b000000 -> q=0, full=0, match=0 (no false match on an empty register).
- **Serial fill and match:** WIDTH=6, mode=01, rot=0, sin sequence 1,0,1,1,0,0 over 6 edges, pattern=6'b001101:
  - after edge 5: full=0, match=0
  - after edge 6: q=6'b001101, full=1, match=1
  - one more shift with sin=1: q=6'b100110, match=0
- **Load then shift left:** load pin=6'b100101 -> q=6'b100101, full=1, so_l=1. Then mode=10, sin=0 -> q=6'b001010, so_l=0.
- **Rotate:**
  - from q=6'b100101, mode=01, rot=1 -> q=6'b110010
  - from q=6'b100101, mode=10, rot=1 -> q=6'b001011
  - full unchanged in both cases
- **Fill saturation:** 10 non-rotating shifts from reset with WIDTH=6 -> count holds at 6 with no wrap, and full stays 1.
- **Reset mid-fill:** reset asserted after 3 shifts -> q=0, full=0. A subsequent load of pin=6'b111111 gives q=6'b111111 and full=1 on the next edge.

Source files
------------

// File: rtl/univ_shiftreg_pkg.sv
// Shared definitions for the universal shift register: operation modes and
// the sizing helper for the fill counter.
package univ_shiftreg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Bits needed to hold a fill count in the range 0..max inclusive.
    function automatic int unsigned cnt_width(input int unsigned max);
        return $clog2(max + 1);
    endfunction

endpackage : univ_shiftreg_pkg

// File: rtl/univ_shiftreg_fill_counter.sv
// Saturating fill counter: counts shift steps up to MAX, jumps to MAX on load,
// and never wraps. full is a decode of the registered count.
module fill_counter
    import univ_shiftreg_pkg::*;
#(
    parameter int unsigned MAX = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    input  logic                      load,
    output logic [cnt_width(MAX)-1:0] count,
    output logic                      full
);

    localparam int unsigned CW = cnt_width(MAX);
    localparam logic [CW-1:0] COUNT_MAX = CW'(MAX);

    logic [CW-1:0] count_next;

    // Load dominates increment; increment stops once the count reaches MAX.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = COUNT_MAX;
        end else if (inc && (count != COUNT_MAX)) begin
            count_next = count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign full = (count == COUNT_MAX);

endmodule : fill_counter

// File: rtl/univ_shiftreg.sv
// Universal shift register with hold/shift/rotate/load modes, a saturating
// fill counter and a pattern comparator that only reports once full.
module univ_shiftreg
    import univ_shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             full,
    output logic             match
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] q_next;
    logic             fill_in_r;
    logic             fill_in_l;
    logic             cnt_inc;
    logic             cnt_load;
    logic [CW-1:0]    count;

    // Bit entering at the vacated end: wrapped-around bit when rotating, else sin.
    assign fill_in_r = rot ? q[0]       : sin;
    assign fill_in_l = rot ? q[WIDTH-1] : sin;

    always_comb begin
        q_next = q;
        case (mode)
            MODE_SHR:  q_next = {fill_in_r, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], fill_in_l};
            MODE_LOAD: q_next = pin;
            default:   q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    // Only shifts that take in new serial data count toward the fill level.
    assign cnt_inc  = ((mode == MODE_SHR) || (mode == MODE_SHL)) && !rot;
    assign cnt_load = (mode == MODE_LOAD);

    fill_counter #(
        .MAX (WIDTH)
    ) u_fill (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .load  (cnt_load),
        .count (count),
        .full  (full)
    );

    assign so_r  = q[0];
    assign so_l  = q[WIDTH-1];
    assign match = full && (q == pattern);

endmodule : univ_shiftreg

// File: tb/tb_univ_shiftreg.sv
// Directed testbench for univ_shiftreg at WIDTH=6 with hand-computed expectations.
module tb_univ_shiftreg;

    localparam int unsigned WIDTH = 6;

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic             rot;
    logic             sin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic             full;
    logic             match;

    int checks;
    int passed;

    univ_shiftreg #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .rot     (rot),
        .sin     (sin),
        .pin     (pin),
        .pattern (pattern),
        .q       (q),
        .so_r    (so_r),
        .so_l    (so_l),
        .full    (full),
        .match   (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs for one edge, then settle 1 time unit past it.
    task automatic step(input logic r, input logic [1:0] m, input logic ro,
                        input logic s, input logic [WIDTH-1:0] p);
        rst  = r;
        mode = m;
        rot  = ro;
        sin  = s;
        pin  = p;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mode = 2'b00;
    endtask

    task automatic test_reset();
        pattern = 6'b000000;
        step(1'b1, 2'b11, 1'b0, 1'b1, 6'b111111);
        checks++;
        if (q !== 6'b000000) $display("FAIL reset_q: got %b want %b", q, 6'b000000);
        else passed++;
        checks++;
        if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full);
        else passed++;
        checks++;
        if (match !== 1'b0) $display("FAIL reset_match: got %b want 0", match);
        else passed++;
        checks++;
        if ({so_l, so_r} !== 2'b00) $display("FAIL reset_so: got %b want 00", {so_l, so_r});
        else passed++;
    endtask

    task automatic test_serial_fill();
        logic [5:0] bits;
        bits = 6'b001101;  // sin order (first..last) = 1,0,1,1,0,0 read from bit 0 up
        pattern = 6'b001101;
        step(1'b1, 2'b00, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 1'b0, bits[i], '0);
        checks++;
        if ({full, match} !== 2'b00) $display("FAIL fill_edge5: got full/match %b want 00", {full, match});
        else passed++;
        step(1'b0, 2'b01, 1'b0, bits[5], '0);
        checks++;
        if (q !== 6'b001101) $display("FAIL fill_q: got %b want %b", q, 6'b001101);
        else passed++;
        checks++;
        if ({full, match} !== 2'b11) $display("FAIL fill_edge6: got full/match %b want 11", {full, match});
        else passed++;
        step(1'b0, 2'b01, 1'b0, 1'b1, '0);
        checks++;
        if (q !== 6'b100110) $display("FAIL fill_extra_q: got %b want %b", q, 6'b100110);
        else passed++;
        checks++;
        if ({full, match} !== 2'b10) $display("FAIL fill_extra_match: got full/match %b want 10", {full, match});
        else passed++;
        // Comparator reacts to pattern without a clock edge.
        pattern = 6'b100110;
        #1;
        checks++;
        if (match !== 1'b1) $display("FAIL pattern_comb: got %b want 1", match);
        else passed++;
    endtask

    task automatic test_load_shl();
        step(1'b1, 2'b00, 1'b0, 1'b0, '0);
        step(1'b0, 2'b11, 1'b1, 1'b0, 6'b100101);
        checks++;
        if ({q, full, so_l, so_r} !== {6'b100101, 1'b1, 1'b1, 1'b1})
            $display("FAIL load: got q=%b full=%b so_l=%b so_r=%b want 100101 1 1 1", q, full, so_l, so_r);
        else passed++;
        step(1'b0, 2'b10, 1'b0, 1'b0, '0);
        checks++;
        if ({q, so_l} !== {6'b001010, 1'b0}) $display("FAIL shl: got q=%b so_l=%b want 001010 0", q, so_l);
        else passed++;
        step(1'b0, 2'b00, 1'b0, 1'b1, 6'b111111);
        checks++;
        if ({q, full} !== {6'b001010, 1'b1}) $display("FAIL hold: got q=%b full=%b want 001010 1", q, full);
        else passed++;
    endtask

    task automatic test_rotate();
        step(1'b0, 2'b11, 1'b0, 1'b0, 6'b100101);
        step(1'b0, 2'b01, 1'b1, 1'b0, '0);
        checks++;
        if ({q, full} !== {6'b110010, 1'b1}) $display("FAIL rot_r: got q=%b full=%b want 110010 1", q, full);
        else passed++;
        step(1'b0, 2'b11, 1'b0, 1'b0, 6'b100101);
        step(1'b0, 2'b10, 1'b1, 1'b0, '0);
        checks++;
        if ({q, full} !== {6'b001011, 1'b1}) $display("FAIL rot_l: got q=%b full=%b want 001011 1", q, full);
        else passed++;
        // Rotation must not advance the fill count from an empty register.
        step(1'b1, 2'b00, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 1'b0, 1'b1, '0);
        step(1'b0, 2'b10, 1'b1, 1'b0, '0);
        checks++;
        if (full !== 1'b0) $display("FAIL rot_no_count: got full=%b want 0", full);
        else passed++;
        step(1'b0, 2'b10, 1'b0, 1'b0, '0);
        checks++;
        if (full !== 1'b1) $display("FAIL rot_then_shift: got full=%b want 1", full);
        else passed++;
    endtask

    task automatic test_saturation();
        pattern = 6'b000000;
        step(1'b1, 2'b00, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            // Alternate direction: count tracks shifts, not positions.
            step(1'b0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0, '0);
            if (i == 4) begin
                checks++;
                if (full !== 1'b0) $display("FAIL sat_shift5: got full=%b want 0", full);
                else passed++;
            end
        end
        checks++;
        if (dut.u_fill.count !== 3'd6) $display("FAIL sat_count: got %0d want 6", dut.u_fill.count);
        else passed++;
        checks++;
        if ({full, match} !== 2'b11) $display("FAIL sat_full_match: got full/match %b want 11", {full, match});
        else passed++;
    endtask

    task automatic test_reset_mid_fill();
        step(1'b1, 2'b00, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 1'b0, 1'b1, '0);
        step(1'b1, 2'b11, 1'b0, 1'b1, 6'b101010);
        checks++;
        if ({q, full} !== {6'b000000, 1'b0}) $display("FAIL rst_mid: got q=%b full=%b want 000000 0", q, full);
        else passed++;
        step(1'b0, 2'b11, 1'b0, 1'b0, 6'b111111);
        checks++;
        if ({q, full} !== {6'b111111, 1'b1}) $display("FAIL rst_then_load: got q=%b full=%b want 111111 1", q, full);
        else passed++;
        // After reset, a full serial refill is needed again.
        step(1'b1, 2'b00, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 1'b0, 1'b1, '0);
        checks++;
        if ({q, full} !== {6'b000111, 1'b0}) $display("FAIL rst_refill: got q=%b full=%b want 000111 0", q, full);
        else passed++;
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        rst     = 1'b1;
        mode    = 2'b00;
        rot     = 1'b0;
        sin     = 1'b0;
        pin     = '0;
        pattern = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_serial_fill();
        test_load_shl();
        test_rotate();
        test_saturation();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_univ_shiftreg
